// File: rtl/doorbell_irq_arbiter_pkg.sv
// Shared definitions for the doorbell IRQ arbiter.
// Contents:
//   db_state_e : delivery FSM states (DB_IDLE / DB_BUSY)
//   ARB_RR     : round-robin arbitration mode value
//   ARB_FIXED  : fixed-priority arbitration mode value (lowest index wins)
//   id_width() : source-id width for a given source count, never below 1
package doorbell_irq_arbiter_pkg;

  typedef enum logic {
    DB_IDLE = 1'b0,
    DB_BUSY = 1'b1
  } db_state_e;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/doorbell_irq_arbiter_rr_arbiter.sv
// Combinational request arbiter for the doorbell IRQ arbiter.
// In round-robin mode the search starts at ptr and wraps. In fixed mode the
// search starts at index 0, so the lowest pending index wins.
// Ports:
//   req    in   NUM_SRC  request vector (pending doorbells)
//   ptr    in   ID_W     round-robin start index (< NUM_SRC)
//   mode   in   1        0 = round-robin, 1 = fixed priority
//   gnt_id out  ID_W     index of the winning request (0 when none)
//   any    out  1        at least one request is set
module doorbell_rr_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               mode,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  always_comb begin
    int unsigned base;
    int unsigned idx;
    gnt_id = '0;
    any    = 1'b0;
    base   = 0;
    idx    = 0;
    if (!mode) begin
      base = 32'(ptr);
    end
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      // Rotated index with wrap; base is always below NUM_SRC.
      idx = base + off;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      if (!any && req[idx]) begin
        any    = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/doorbell_irq_arbiter.sv
// Doorbell IRQ arbiter: captures ready+flags doorbells from NUM_SRC execution
// units into per-source pending registers, arbitrates them and delivers one
// doorbell at a time to the HCI over a valid/ack handshake. Events coalesced
// into an already-pending doorbell set a sticky overflow bit.
// Default build: src0 = FPU, src1 = SIMD.
// Ports:
//   clk        in   1               rising-edge clock
//   rst        in   1               asynchronous active-high reset
//   src_ready  in   NUM_SRC         per-source doorbell event
//   src_flags  in   NUM_SRC*FLAG_W  flags, source i at [i*FLAG_W +: FLAG_W]
//   src_mask   in   NUM_SRC         1 = ignore new events from source i
//   ovf_clr    in   NUM_SRC         pulse clears overflow[i]
//   hci_valid  out  1               doorbell presented to HCI
//   hci_src_id out  ID_W            index of presented source
//   hci_flags  out  FLAG_W          flags of presented doorbell
//   hci_ack    in   1               HCI accept, effective while hci_valid=1
//   pending    out  NUM_SRC         per-source pending bits
//   overflow   out  NUM_SRC         sticky coalescing indicator
module doorbell_irq_arbiter
  import doorbell_irq_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_SRC  = 2,
  parameter  int unsigned FLAG_W   = 4,
  parameter  int unsigned ARB_MODE = ARB_RR,
  localparam int unsigned ID_W     = id_width(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*FLAG_W-1:0] src_flags,
  input  logic [NUM_SRC-1:0]        src_mask,
  input  logic [NUM_SRC-1:0]        ovf_clr,
  output logic                      hci_valid,
  output logic [ID_W-1:0]           hci_src_id,
  output logic [FLAG_W-1:0]         hci_flags,
  input  logic                      hci_ack,
  output logic [NUM_SRC-1:0]        pending,
  output logic [NUM_SRC-1:0]        overflow
);

  db_state_e          state_q, state_d;
  logic [FLAG_W-1:0]  pflags_q [NUM_SRC];
  logic [FLAG_W-1:0]  pflags_d [NUM_SRC];
  logic [NUM_SRC-1:0] pending_d, overflow_d;
  logic [NUM_SRC-1:0] event_v;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    gnt_id;
  logic               any_pending;
  logic               grant_fire;
  logic               hci_valid_d;
  logic [ID_W-1:0]    hci_src_id_d;
  logic [FLAG_W-1:0]  hci_flags_d;

  assign event_v    = src_ready & ~src_mask;
  assign grant_fire = (state_q == DB_IDLE) && any_pending;

  doorbell_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (pending),
    .ptr    (rr_ptr_q),
    .mode   (ARB_MODE == ARB_FIXED),
    .gnt_id (gnt_id),
    .any    (any_pending)
  );

  // Per-source capture. A source granted this cycle is being emptied, so a
  // simultaneous event starts a fresh doorbell instead of coalescing.
  always_comb begin
    logic [FLAG_W-1:0] new_flags;
    logic              granted;
    logic              ovf_set;
    new_flags = '0;
    granted   = 1'b0;
    ovf_set   = 1'b0;
    pending_d  = pending;
    overflow_d = overflow;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pflags_d[i] = pflags_q[i];
      new_flags   = src_flags[i*FLAG_W +: FLAG_W];
      granted     = grant_fire && (gnt_id == ID_W'(i));
      ovf_set     = 1'b0;
      if (granted) begin
        pending_d[i] = event_v[i];
        if (event_v[i]) begin
          pflags_d[i] = new_flags;
        end
      end else if (event_v[i]) begin
        if (pending[i]) begin
          pflags_d[i] = pflags_q[i] | new_flags;
          ovf_set     = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          pflags_d[i]  = new_flags;
        end
      end
      if (ovf_set) begin
        overflow_d[i] = 1'b1;
      end else if (ovf_clr[i]) begin
        overflow_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    hci_valid_d  = hci_valid;
    hci_src_id_d = hci_src_id;
    hci_flags_d  = hci_flags;
    rr_ptr_d     = rr_ptr_q;
    case (state_q)
      DB_IDLE: begin
        if (any_pending) begin
          state_d      = DB_BUSY;
          hci_valid_d  = 1'b1;
          hci_src_id_d = gnt_id;
          hci_flags_d  = pflags_q[gnt_id];
          if (ARB_MODE == ARB_RR) begin
            rr_ptr_d = (gnt_id == ID_W'(NUM_SRC - 1)) ? '0 : gnt_id + 1'b1;
          end
        end
      end
      DB_BUSY: begin
        if (hci_ack) begin
          state_d     = DB_IDLE;
          hci_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = DB_IDLE;
        hci_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DB_IDLE;
      rr_ptr_q   <= '0;
      hci_valid  <= 1'b0;
      hci_src_id <= '0;
      hci_flags  <= '0;
      pending    <= '0;
      overflow   <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        pflags_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hci_valid  <= hci_valid_d;
      hci_src_id <= hci_src_id_d;
      hci_flags  <= hci_flags_d;
      pending    <= pending_d;
      overflow   <= overflow_d;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        pflags_q[i] <= pflags_d[i];
      end
    end
  end

endmodule

// File: tb/tb_doorbell_irq_arbiter.sv
// Directed testbench for doorbell_irq_arbiter: two 2-source builds (round-robin
// and fixed priority) sharing one stimulus set, plus a 5-source 8-bit build.
module tb_doorbell_irq_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0] ready, mask, clr;
  logic [7:0] flags;
  logic       ack;
  logic       v0, v1;
  logic       id0, id1;
  logic [3:0] f0, f1;
  logic [1:0] p0, p1, o0, o1;

  logic [4:0]  ready2, mask2, clr2;
  logic [39:0] flags2;
  logic        ack2;
  logic        v2;
  logic [2:0]  id2;
  logic [7:0]  f2;
  logic [4:0]  p2, o2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  doorbell_irq_arbiter #(.NUM_SRC(2), .FLAG_W(4), .ARB_MODE(0)) d0 (
    .clk(clk), .rst(rst), .src_ready(ready), .src_flags(flags), .src_mask(mask),
    .ovf_clr(clr), .hci_valid(v0), .hci_src_id(id0), .hci_flags(f0),
    .hci_ack(ack), .pending(p0), .overflow(o0));

  doorbell_irq_arbiter #(.NUM_SRC(2), .FLAG_W(4), .ARB_MODE(1)) d1 (
    .clk(clk), .rst(rst), .src_ready(ready), .src_flags(flags), .src_mask(mask),
    .ovf_clr(clr), .hci_valid(v1), .hci_src_id(id1), .hci_flags(f1),
    .hci_ack(ack), .pending(p1), .overflow(o1));

  doorbell_irq_arbiter #(.NUM_SRC(5), .FLAG_W(8), .ARB_MODE(0)) d2 (
    .clk(clk), .rst(rst), .src_ready(ready2), .src_flags(flags2), .src_mask(mask2),
    .ovf_clr(clr2), .hci_valid(v2), .hci_src_id(id2), .hci_flags(f2),
    .hci_ack(ack2), .pending(p2), .overflow(o2));

  // Advance to 1 time unit after the next rising edge; each call starts a new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ready = '0; flags = '0; mask = '0; clr = '0; ack = 1'b0;
    ready2 = '0; flags2 = '0; mask2 = '0; clr2 = '0; ack2 = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL rst_valid0 got=%0h exp=0", v0); end
    total++; if (id0 !== 1'b0) begin bad++; $display("FAIL rst_id0 got=%0h exp=0", id0); end
    total++; if (f0 !== 4'h0) begin bad++; $display("FAIL rst_flags0 got=%0h exp=0", f0); end
    total++; if (p0 !== 2'b00) begin bad++; $display("FAIL rst_pending0 got=%0b exp=00", p0); end
    total++; if (o0 !== 2'b00) begin bad++; $display("FAIL rst_overflow0 got=%0b exp=00", o0); end
    total++; if ({v1, f1, p1, o1} !== 9'h0) begin bad++; $display("FAIL rst_d1 got=%0h exp=0", {v1, f1, p1, o1}); end
    total++; if ({v2, id2, f2, p2, o2} !== 22'h0) begin bad++; $display("FAIL rst_d2 got=%0h exp=0", {v2, id2, f2, p2, o2}); end
  endtask

  task automatic test_fpu_only();
    do_reset();
    ready = 2'b01; flags = 8'h0A;          // cycle 0
    step();                                // cycle 1
    ready = '0; flags = '0;
    total++; if (p0 !== 2'b01) begin bad++; $display("FAIL t1_pending_c1 got=%0b exp=01", p0); end
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL t1_valid_c1 got=%0h exp=0", v0); end
    step();                                // cycle 2
    total++; if (v0 !== 1'b1) begin bad++; $display("FAIL t1_valid_c2 got=%0h exp=1", v0); end
    total++; if (id0 !== 1'b0) begin bad++; $display("FAIL t1_id_c2 got=%0h exp=0", id0); end
    total++; if (f0 !== 4'hA) begin bad++; $display("FAIL t1_flags_c2 got=%0h exp=a", f0); end
    total++; if (p0 !== 2'b00) begin bad++; $display("FAIL t1_pending_c2 got=%0b exp=00", p0); end
    step();                                // cycle 3
    step();                                // cycle 4
    total++; if ({v0, f0} !== 5'h1A) begin bad++; $display("FAIL t1_hold_c4 got=%0h exp=1a", {v0, f0}); end
    ack = 1'b1;
    step();                                // cycle 5
    ack = 1'b0;
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL t1_valid_c5 got=%0h exp=0", v0); end
    total++; if (p0 !== 2'b00) begin bad++; $display("FAIL t1_pending_c5 got=%0b exp=00", p0); end
  endtask

  task automatic test_fairness();
    do_reset();
    ready = 2'b11; flags = 8'h21;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 8 && !v0; c++) step();
      total++; if (v0 !== 1'b1) begin bad++; $display("FAIL t2_wait_valid grant=%0d got=%0h exp=1", g, v0); end
      total++; if (id0 !== 1'(g % 2)) begin bad++; $display("FAIL t2_rr_id grant=%0d got=%0h exp=%0h", g, id0, g % 2); end
      total++; if ({v1, id1} !== 2'b10) begin bad++; $display("FAIL t2_fixed_id grant=%0d got=%0b exp=10", g, {v1, id1}); end
      ack = 1'b1;
      step();
      ack = 1'b0;
    end
    ready = '0;
  endtask

  task automatic test_coalesce();
    do_reset();
    ready = 2'b11; flags = {4'h1, 4'h3};   // cycle 0
    step();                                // cycle 1
    ready = '0; flags = '0;
    total++; if (p0 !== 2'b11) begin bad++; $display("FAIL t3_pending_c1 got=%0b exp=11", p0); end
    step();                                // cycle 2: src0 delivered
    total++; if ({v0, id0, f0} !== 6'h23) begin bad++; $display("FAIL t3_first got=%0h exp=23", {v0, id0, f0}); end
    ready = 2'b10; flags = {4'h4, 4'h0};
    step();                                // cycle 3
    ready = '0; flags = '0;
    total++; if (o0 !== 2'b10) begin bad++; $display("FAIL t3_overflow_set got=%0b exp=10", o0); end
    total++; if (p0 !== 2'b10) begin bad++; $display("FAIL t3_pending_c3 got=%0b exp=10", p0); end
    ack = 1'b1;
    step();                                // cycle 4
    ack = 1'b0;
    step();                                // cycle 5
    total++; if ({v0, id0, f0} !== 6'h35) begin bad++; $display("FAIL t3_coalesced got=%0h exp=35", {v0, id0, f0}); end
    ack = 1'b1; clr = 2'b10;
    step();                                // cycle 6
    ack = 1'b0; clr = '0;
    total++; if (o0 !== 2'b00) begin bad++; $display("FAIL t3_overflow_clr got=%0b exp=00", o0); end
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL t3_valid_c6 got=%0h exp=0", v0); end
  endtask

  task automatic test_collision();
    do_reset();
    ready = 2'b01; flags = 8'h09;          // cycle 0
    step();                                // cycle 1: grant edge ahead
    flags = 8'h02;
    step();                                // cycle 2
    ready = '0; flags = '0;
    total++; if ({v0, f0} !== 5'h19) begin bad++; $display("FAIL t4_old_flags got=%0h exp=19", {v0, f0}); end
    total++; if (p0 !== 2'b01) begin bad++; $display("FAIL t4_rearmed got=%0b exp=01", p0); end
    total++; if (o0 !== 2'b00) begin bad++; $display("FAIL t4_no_overflow got=%0b exp=00", o0); end
    ack = 1'b1;
    step();                                // cycle 3
    ack = 1'b0;
    step();                                // cycle 4
    total++; if ({v0, f0, p0} !== 7'h48) begin bad++; $display("FAIL t4_new_flags got=%0h exp=48", {v0, f0, p0}); end
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_mask_stray_ack();
    do_reset();
    mask = 2'b10; ready = 2'b10; flags = 8'h70;
    step();
    ready = '0; flags = '0;
    total++; if (p0 !== 2'b00) begin bad++; $display("FAIL t5_masked got=%0b exp=00", p0); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    total++; if ({v0, p0, o0} !== 5'h00) begin bad++; $display("FAIL t5_stray_ack got=%0h exp=0", {v0, p0, o0}); end
    mask = 2'b00; ready = 2'b11; flags = 8'h61;  // cycle 0
    step();                                      // cycle 1
    ready = '0; flags = '0; mask = 2'b10;
    total++; if (p0 !== 2'b11) begin bad++; $display("FAIL t5_pending got=%0b exp=11", p0); end
    step();                                      // cycle 2
    total++; if ({v0, id0, f0} !== 6'h21) begin bad++; $display("FAIL t5_first got=%0h exp=21", {v0, id0, f0}); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    total++; if ({v0, id0, f0} !== 6'h36) begin bad++; $display("FAIL t5_masked_delivery got=%0h exp=36", {v0, id0, f0}); end
    ack = 1'b1;
    step();
    ack = 1'b0; mask = '0;
  endtask

  task automatic test_wide_rr();
    do_reset();
    ready2 = 5'b10100;
    flags2 = '0; flags2[39:32] = 8'hC3; flags2[23:16] = 8'h5A;   // cycle 0
    step();                                                       // cycle 1
    ready2 = '0; flags2 = '0;
    total++; if (p2 !== 5'b10100) begin bad++; $display("FAIL t6w_pending got=%0b exp=10100", p2); end
    step();                                                       // cycle 2
    total++; if ({v2, id2, f2} !== 12'hA5A) begin bad++; $display("FAIL t6w_grant2 got=%0h exp=a5a", {v2, id2, f2}); end
    ack2 = 1'b1;
    step();                                                       // cycle 3
    ack2 = 1'b0;
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL t6w_valid_c3 got=%0h exp=0", v2); end
    step();                                                       // cycle 4
    total++; if ({v2, id2, f2} !== 12'hCC3) begin bad++; $display("FAIL t6w_grant4 got=%0h exp=cc3", {v2, id2, f2}); end
    ack2 = 1'b1; ready2 = 5'b00011; flags2[15:0] = 16'h2211;
    step();                                                       // cycle 5
    ack2 = 1'b0; ready2 = '0; flags2 = '0;
    total++; if ({v2, p2} !== 6'b000011) begin bad++; $display("FAIL t6w_c5 got=%0b exp=000011", {v2, p2}); end
    step();                                                       // cycle 6: wrapped to 0
    total++; if ({v2, id2, f2} !== 12'h811) begin bad++; $display("FAIL t6w_wrap got=%0h exp=811", {v2, id2, f2}); end
  endtask

  // Runs directly after test_wide_rr so d2 is still busy with src1 pending.
  task automatic test_reset_mid_busy();
    ready = 2'b11; flags = 8'h2B;          // cycle 0
    step();                                // cycle 1
    ready = '0; flags = '0;
    step();                                // cycle 2
    total++; if ({v0, v2} !== 2'b11) begin bad++; $display("FAIL t6_busy got=%0b exp=11", {v0, v2}); end
    #2 rst = 1'b1;
    #1;
    total++; if ({v0, p0, o0, f0} !== 9'h0) begin bad++; $display("FAIL t6_async_d0 got=%0h exp=0", {v0, p0, o0, f0}); end
    total++; if ({v2, id2, f2, p2} !== 17'h0) begin bad++; $display("FAIL t6_async_d2 got=%0h exp=0", {v2, id2, f2, p2}); end
    step();
    rst = 1'b0;
    ready = 2'b01; flags = 8'h0B;          // cycle 0 after release
    ready2 = 5'b10001; flags2 = '0; flags2[39:32] = 8'h44; flags2[7:0] = 8'h81;
    step();                                // cycle 1
    ready = '0; flags = '0; ready2 = '0; flags2 = '0;
    total++; if ({v0, p0} !== 3'b001) begin bad++; $display("FAIL t6_c1_d0 got=%0b exp=001", {v0, p0}); end
    total++; if ({v2, p2} !== 6'b010001) begin bad++; $display("FAIL t6_c1_d2 got=%0b exp=010001", {v2, p2}); end
    step();                                // cycle 2
    total++; if ({v0, id0, f0} !== 6'h2B) begin bad++; $display("FAIL t6_c2_d0 got=%0h exp=2b", {v0, id0, f0}); end
    total++; if ({v2, id2, f2} !== 12'h881) begin bad++; $display("FAIL t6_c2_d2 got=%0h exp=881", {v2, id2, f2}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fpu_only();
    test_fairness();
    test_coalesce();
    test_collision();
    test_mask_stray_ack();
    test_wide_rr();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
